fir_folded: RTL and testbench



---
 rtl/fir_folded.sv | 163 ++++++++++++++++
 tb/tb_fir_folded.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_folded.sv
// Folded FIR: one shared MAC walks all taps per sample over a circular delay line.
// Programmable coefficients, valid/ready streams, selectable rounding, output saturation.
module fir_folded #(
  parameter int WL      = 14,
  parameter int COEF_WL = 14,
  parameter int TAP_NUM = 37,
  parameter int ACC_WL  = 34,
  parameter int OUT_WL  = 20,
  parameter int SHIFT   = 8,
  parameter int ROUND   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [WL-1:0]        in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic signed [OUT_WL-1:0]    out_data,
  input  logic                        out_ready,
  input  logic                        coef_we,
  input  logic [$clog2(TAP_NUM)-1:0]  coef_addr,
  input  logic signed [COEF_WL-1:0]   coef_wdata,
  input  logic                        flush
);

  localparam int AW = $clog2(TAP_NUM);
  localparam int PW = WL + COEF_WL;
  localparam int EW = ACC_WL + 1;
  localparam int HW = EW - OUT_WL + 1;
  localparam logic [AW-1:0] LAST = AW'(TAP_NUM - 1);
  localparam logic [EW-1:0] RND =
    (ROUND != 0) ? (EW'(1) << (SHIFT - 1)) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                     r_state;
  logic signed [COEF_WL-1:0]  r_coef [TAP_NUM];
  logic signed [WL-1:0]       r_buf  [TAP_NUM];
  logic [AW-1:0]              r_wptr;
  logic [AW-1:0]              r_k;
  logic [AW-1:0]              r_idx;
  logic signed [ACC_WL-1:0]   r_acc;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic signed [OUT_WL-1:0]   r_out_data;

  logic signed [COEF_WL-1:0]  w_c;
  logic signed [WL-1:0]       w_d;
  logic signed [PW-1:0]       w_ce;
  logic signed [PW-1:0]       w_de;
  logic signed [PW-1:0]       w_prod;
  logic signed [ACC_WL-1:0]   w_prod_x;
  logic signed [ACC_WL-1:0]   w_acc_nxt;
  logic signed [EW-1:0]       w_rnd;
  logic signed [EW-1:0]       w_shf;
  logic [HW-1:0]              w_hi;
  logic                       w_fits;
  logic signed [OUT_WL-1:0]   w_sat;
  logic                       w_last;
  logic                       w_coef_wr;
  logic [AW-1:0]              w_wptr_nxt;
  logic [AW-1:0]              w_idx_nxt;

  assign w_c      = r_coef[r_k];
  assign w_d      = r_buf[r_idx];
  assign w_ce     = {{WL{w_c[COEF_WL-1]}}, w_c};
  assign w_de     = {{COEF_WL{w_d[WL-1]}}, w_d};
  assign w_prod   = w_ce * w_de;
  assign w_prod_x = {{(ACC_WL-PW){w_prod[PW-1]}}, w_prod};
  assign w_acc_nxt = r_acc + w_prod_x;

  // One guard bit so the rounding offset cannot wrap a full-scale sum.
  assign w_rnd  = {w_acc_nxt[ACC_WL-1], w_acc_nxt} + RND;
  assign w_shf  = w_rnd >>> SHIFT;
  assign w_hi   = w_shf[EW-1:OUT_WL-1];
  assign w_fits = (&w_hi) | ~(|w_hi);
  assign w_sat  = w_fits ? w_shf[OUT_WL-1:0] :
                  w_shf[EW-1] ? {1'b1, {(OUT_WL-1){1'b0}}} :
                                {1'b0, {(OUT_WL-1){1'b1}}};

  assign w_last     = (r_k == LAST);
  assign w_wptr_nxt = (r_wptr == LAST) ? '0 : r_wptr + AW'(1);
  assign w_idx_nxt  = (r_idx == '0) ? LAST : r_idx - AW'(1);
  assign w_coef_wr  = coef_we && (r_state == S_IDLE) &&
                      (int'(coef_addr) < TAP_NUM);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAP_NUM; i++) begin
        r_coef[i] <= '0;
        r_buf[i]  <= '0;
      end
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_k         <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_coef_wr) begin
        r_coef[coef_addr] <= coef_wdata;
      end
      if (flush) begin
        for (int i = 0; i < TAP_NUM; i++) begin
          r_buf[i] <= '0;
        end
        r_state     <= S_IDLE;
        r_wptr      <= '0;
        r_k         <= '0;
        r_idx       <= '0;
        r_acc       <= '0;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (in_valid) begin
              r_buf[r_wptr] <= in_data;
              r_acc         <= '0;
              r_k           <= '0;
              r_idx         <= r_wptr;
              r_in_ready    <= 1'b0;
              r_state       <= S_MAC;
            end
          end
          S_MAC: begin
            r_acc <= w_acc_nxt;
            r_k   <= r_k + AW'(1);
            r_idx <= w_idx_nxt;
            if (w_last) begin
              r_wptr      <= w_wptr_nxt;
              r_out_data  <= w_sat;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end
          end
          S_OUT: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_folded.sv
// Directed bench for fir_folded: impulse, latency, backpressure, flush,
// saturation, rounding (round and truncate instances) and mid-run reset.
module tb_fir_folded;

  localparam int WL = 14;
  localparam int CW = 14;
  localparam int N  = 37;
  localparam int OW = 20;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic coef_we = 1'b0;
  logic flush = 1'b0;
  logic signed [WL-1:0] in_data = '0;
  logic [AW-1:0] coef_addr = '0;
  logic signed [CW-1:0] coef_wdata = '0;

  logic in_ready, out_valid, in_ready_t, out_valid_t;
  logic signed [OW-1:0] out_data, out_data_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_folded #(.ROUND(1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .flush(flush)
  );

  fir_folded #(.ROUND(0)) u_trunc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_t),
    .out_valid(out_valid_t), .out_data(out_data_t), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .flush(flush)
  );

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr_coef(input int a, input int v);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = AW'(a);
    coef_wdata = CW'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic run_sample(input int d, input bit we,
                            input int wa, input int wv,
                            output logic signed [OW-1:0] y,
                            output logic signed [OW-1:0] yt,
                            output logic vt);
    int n;
    @(negedge clk);
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data = WL'(d);
    coef_we = we;
    coef_addr = AW'(wa);
    coef_wdata = CW'(wv);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", 64'(out_valid), 1);
    y = out_data;
    yt = out_data_t;
    vt = out_valid_t;
  endtask

  task automatic send(input int d, input int exp, input string tag);
    logic signed [OW-1:0] y, yt;
    logic vt;
    run_sample(d, 1'b0, 0, 0, y, yt, vt);
    chk(tag, y, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [OW-1:0] y, yt;
    logic vt;
    int lat;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready_t", 64'(in_ready_t), 1);
    rst = 1'b0;

    // impulse response with coef[k] = k+1
    for (int k = 0; k < N; k++) wr_coef(k, k + 1);
    for (int i = 0; i < 41; i++) begin
      send((i == 0) ? 256 : 0, (i < N) ? i + 1 : 0,
           $sformatf("impulse_%0d", i));
    end

    // latency and in_ready timing
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 256;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_in_ready_low", 64'(in_ready), 0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 37);
    chk("lat_in_ready_out", 64'(in_ready), 0);
    chk("lat_data", out_data, 1);
    @(negedge clk);
    chk("lat_next_ready", 64'(in_ready), 1);
    chk("lat_valid_drop", 64'(out_valid), 0);

    // backpressure: output held, extra inputs ignored
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_first", out_data, 2);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data = 1000;
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i), 64'(out_valid), 1);
      chk($sformatf("bp_data_%0d", i), out_data, 2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'(out_valid), 0);
    send(0, 3, "bp_after");

    // coefficient write during MAC is dropped
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 0;
    coef_wdata = 50;
    @(negedge clk);
    coef_we = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("mac_we_sample", out_data, 4);
    do_flush();
    send(256, 1, "mac_we_kept");

    // flush with a concurrent coefficient write
    @(negedge clk);
    flush = 1'b1;
    coef_we = 1'b1;
    coef_addr = 0;
    coef_wdata = 5;
    @(negedge clk);
    flush = 1'b0;
    coef_we = 1'b0;
    send(256, 5, "flush_coef_wr");
    wr_coef(0, 1);

    // flush in the middle of MAC
    send(256, 3, "pre_flush");
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("flush_no_valid", 64'(seen), 0);
    chk("flush_ready", 64'(in_ready), 1);
    send(0, 0, "flush_hist_zero");
    send(256, 1, "flush_impulse");

    // saturation
    do_flush();
    for (int k = 0; k < N; k++) wr_coef(k, 8191);
    for (int i = 0; i < N; i++) begin
      run_sample(8191, 1'b0, 0, 0, y, yt, vt);
      if (i == 0) chk("sat_first", y, 262080);
    end
    chk("sat_pos", y, 524287);
    for (int i = 0; i < N; i++) run_sample(-8192, 1'b0, 0, 0, y, yt, vt);
    chk("sat_neg", y, -524288);
    chk("sat_neg_trunc", yt, -524288);

    // rounding versus truncation
    do_flush();
    wr_coef(0, 1);
    for (int k = 1; k < N; k++) wr_coef(k, 0);
    run_sample(128, 1'b0, 0, 0, y, yt, vt);
    chk("rnd_128", y, 1);
    chk("trn_128", yt, 0);
    chk("trn_valid", 64'(vt), 1);
    run_sample(127, 1'b0, 0, 0, y, yt, vt);
    chk("rnd_127", y, 0);
    chk("trn_127", yt, 0);
    run_sample(-129, 1'b0, 0, 0, y, yt, vt);
    chk("rnd_m129", y, -1);
    chk("trn_m129", yt, -1);
    run_sample(256, 1'b1, 0, 3, y, yt, vt);
    chk("same_cycle_we", y, 3);
    chk("same_cycle_we_t", yt, 3);

    // asynchronous reset mid-MAC
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 256;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 1);
    chk("mid_rst_out_valid", 64'(out_valid), 0);
    chk("mid_rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sample(256, 1'b0, 0, 0, y, yt, vt);
    chk("rst_coef_zero", y, 0);
    chk("rst_coef_zero_t", yt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
